// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side hazard signals grouped between the pipeline (master) and hazard_stall_unit (slave).
interface hazard_stall_unit_if;
    logic       ID_EX_MemRead;
    logic       ID_EX_RegWrite;
    logic [4:0] ID_EX_Rd;
    logic       EX_MEM_MemRead;
    logic [4:0] EX_MEM_Rd;
    logic [4:0] IF_ID_Rs;
    logic [4:0] IF_ID_Rt;
    logic       IF_ID_UsesRt;
    logic       ID_Branch;
    logic       ID_Jump;
    logic       ID_MulDiv_Start;
    logic       ID_HiLo_Read;
    logic       EX_BranchTaken;
    logic       PC_Write;
    logic       IF_ID_Write;
    logic       ID_EX_Bubble;
    logic       IF_ID_Flush;
    logic       MulDiv_Busy;
    logic       MulDiv_Issue;

    modport master (
        output ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd,
               IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, ID_Branch, ID_Jump,
               ID_MulDiv_Start, ID_HiLo_Read, EX_BranchTaken,
        input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MulDiv_Busy, MulDiv_Issue
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Rd, EX_MEM_MemRead, EX_MEM_Rd,
               IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, ID_Branch, ID_Jump,
               ID_MulDiv_Start, ID_HiLo_Read, EX_BranchTaken,
        output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MulDiv_Busy, MulDiv_Issue
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Interlock controller: load-use / branch-operand stalls, mult/div busy tracking, branch/jump flushes.
// Optional HAZARD_PERF_CNT_EN adds a saturating stall_cycles counter output.
module hazard_stall_unit #(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_unit_if.slave  pipe_io
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rs_match_ex, rt_match_ex, rs_match_mem, rt_match_mem;
    logic match_ex, match_mem;
    logic load_use, branch_dep, md_hold, stall;
    logic busy;

    // Register 0 is hardwired, so it never creates a dependency.
    always_comb begin
        rs_match_ex  = (pipe_io.ID_EX_Rd != 5'd0) && (pipe_io.ID_EX_Rd == pipe_io.IF_ID_Rs);
        rt_match_ex  = pipe_io.IF_ID_UsesRt && (pipe_io.ID_EX_Rd != 5'd0)
                       && (pipe_io.ID_EX_Rd == pipe_io.IF_ID_Rt);
        rs_match_mem = (pipe_io.EX_MEM_Rd != 5'd0) && (pipe_io.EX_MEM_Rd == pipe_io.IF_ID_Rs);
        rt_match_mem = pipe_io.IF_ID_UsesRt && (pipe_io.EX_MEM_Rd != 5'd0)
                       && (pipe_io.EX_MEM_Rd == pipe_io.IF_ID_Rt);
        match_ex     = rs_match_ex | rt_match_ex;
        match_mem    = rs_match_mem | rt_match_mem;

        busy       = (state_q == BUSY);
        load_use   = pipe_io.ID_EX_MemRead & match_ex;
        branch_dep = pipe_io.ID_Branch & ((pipe_io.ID_EX_RegWrite & match_ex)
                                        | (pipe_io.EX_MEM_MemRead & match_mem));
        md_hold    = busy & (pipe_io.ID_MulDiv_Start | pipe_io.ID_HiLo_Read);
        stall      = load_use | branch_dep | md_hold;
    end

    // A taken branch overrides any stall; a jump only flushes when ID can advance.
    always_comb begin
        pipe_io.PC_Write     = 1'b1;
        pipe_io.IF_ID_Write  = 1'b1;
        pipe_io.ID_EX_Bubble = 1'b0;
        pipe_io.IF_ID_Flush  = 1'b0;
        pipe_io.MulDiv_Issue = 1'b0;
        pipe_io.MulDiv_Busy  = busy;
        if (pipe_io.EX_BranchTaken) begin
            pipe_io.IF_ID_Flush  = 1'b1;
            pipe_io.ID_EX_Bubble = 1'b1;
        end else if (stall) begin
            pipe_io.PC_Write     = 1'b0;
            pipe_io.IF_ID_Write  = 1'b0;
            pipe_io.ID_EX_Bubble = 1'b1;
        end else begin
            pipe_io.IF_ID_Flush  = pipe_io.ID_Jump;
            pipe_io.MulDiv_Issue = pipe_io.ID_MulDiv_Start;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pipe_io.MulDiv_Issue) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;

    // Counts only genuine stall cycles, not ones masked by a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else if (stall && !pipe_io.EX_BranchTaken && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
